// File: rtl/equation_result_acc.sv
// Batch accumulator for the 5-bit z results of the z = x*x + 2*x + y stage.
// Define EQ_ACC_MINMAX_EN to also track the batch minimum and maximum.
module equation_result_acc #(
  parameter  int DATA_W    = 5,
  parameter  int N_SAMPLES = 8,
  localparam int SUM_W     = DATA_W + $clog2(N_SAMPLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               accept_s, last_s, init_s, flush_s;

  // Next-state, accumulation and registered handshake outputs
  always_comb begin
    accept_s = in_valid & (state_q == ACCUM);
    last_s   = accept_s & (count_q == CNT_W'(N_SAMPLES - 1));
    init_s   = ~clear & start & (state_q == IDLE);
    // clear and the result handshake both discard the batch contents
    flush_s  = clear | ((state_q == DONE) & out_ready);

    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;

    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)     state_d = ACCUM; else state_d = IDLE;
        ACCUM:   if (last_s)    state_d = DONE;  else state_d = ACCUM;
        DONE:    if (out_ready) state_d = IDLE;  else state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    if (flush_s || init_s) begin
      count_d = {CNT_W{1'b0}};
      sum_d   = {SUM_W{1'b0}};
    end else if (accept_s) begin
      count_d = count_q + CNT_W'(1);
      sum_d   = sum_q + {{(SUM_W-DATA_W){1'b0}}, in_data};
    end else begin
      count_d = count_q;
      sum_d   = sum_q;
    end

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Control FSM and sum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= {CNT_W{1'b0}};
      sum_q       <= {SUM_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;

`ifdef EQ_ACC_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;

  // Running extremes, restarted together with the sum
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (flush_s || init_s) begin
      min_d = {DATA_W{1'b1}};
      max_d = {DATA_W{1'b0}};
    end else if (accept_s) begin
      if (in_data < min_q) min_d = in_data; else min_d = min_q;
      if (in_data > max_q) max_d = in_data; else max_d = max_q;
    end else begin
      min_d = min_q;
      max_d = max_q;
    end
  end

  // Extreme registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= {DATA_W{1'b1}};
      max_q <= {DATA_W{1'b0}};
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign out_min = min_q;
  assign out_max = max_q;
`else
  assign out_min = {DATA_W{1'b1}};
  assign out_max = {DATA_W{1'b0}};
`endif

endmodule
